// File: rtl/aux_input_conditioner_if.sv
// Board-input bundle: raw switch/button levels in, conditioned level and edge pulses out.
interface aux_input_conditioner_if #(
    parameter int unsigned NBit = 16
);
    logic [NBit-1:0] raw;
    logic [NBit-1:0] level;
    logic [NBit-1:0] rise;
    logic [NBit-1:0] fall;

    modport master (output raw, input level, rise, fall);
    modport slave  (input raw, output level, rise, fall);
endinterface

// File: rtl/aux_input_conditioner.sv
// Per-bit 2-FF synchronizer, tick-based debouncer and rise/fall pulse generator.
// Optional rise auto-repeat while held: `define AUX_INPUT_AUTOREPEAT_EN.
module aux_input_conditioner #(
    parameter int unsigned NBit         = 16,
    parameter int unsigned TickCnt      = 50_000,
    parameter int unsigned StableCnt    = 8,
    parameter int unsigned RepeatDelay  = 500,
    parameter int unsigned RepeatPeriod = 100
) (
    input logic                    clk,
    input logic                    rst_n,
    aux_input_conditioner_if.slave bus
);
    localparam int unsigned PW = (TickCnt > 1) ? $clog2(TickCnt) : 1;
    localparam int unsigned CW = $clog2(StableCnt) + 1;

    if (TickCnt < 1 || StableCnt < 1 || RepeatDelay < 1 || RepeatPeriod < 1) begin : g_bad_cfg
        $error("aux_input_conditioner: TickCnt, StableCnt, RepeatDelay, RepeatPeriod must be >= 1");
    end

    logic [NBit-1:0] s1, s2;
    logic [NBit-1:0] level, rise, fall;
    logic [PW-1:0]   pcnt;
    logic [CW-1:0]   cnt [NBit];
    logic            tick_c;
    logic [NBit-1:0] accept_c;
    logic [NBit-1:0] rep_hit_c;

    assign bus.level = level;
    assign bus.rise  = rise;
    assign bus.fall  = fall;

    assign tick_c = (pcnt == PW'(TickCnt - 1));

    // Debounce sample-rate prescaler.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick_c) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_comb begin
        accept_c = '0;
        for (int i = 0; i < int'(NBit); i++) begin
            accept_c[i] = tick_c && (s2[i] != level[i]) && (cnt[i] == CW'(StableCnt - 1));
        end
    end

`ifdef AUX_INPUT_AUTOREPEAT_EN
    localparam int unsigned RMax = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
    localparam int unsigned RW   = $clog2(RMax + 1);

    logic [RW-1:0]   rep [NBit];
    logic [NBit-1:0] phase;

    // phase=0: waiting out the initial delay; phase=1: periodic repeats.
    always_comb begin
        rep_hit_c = '0;
        for (int i = 0; i < int'(NBit); i++) begin
            rep_hit_c[i] = tick_c && level[i] && !accept_c[i] &&
                           (rep[i] == (phase[i] ? RW'(RepeatPeriod - 1) : RW'(RepeatDelay - 1)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
            for (int i = 0; i < int'(NBit); i++) begin
                rep[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NBit); i++) begin
                if (!level[i] || accept_c[i]) begin
                    rep[i]   <= '0;
                    phase[i] <= 1'b0;
                end else if (tick_c) begin
                    if (rep_hit_c[i]) begin
                        rep[i]   <= '0;
                        phase[i] <= 1'b1;
                    end else begin
                        rep[i] <= rep[i] + RW'(1);
                    end
                end
            end
        end
    end
`else
    assign rep_hit_c = '0;
`endif

    // Synchronizer, stability counters and registered level/pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < int'(NBit); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= bus.raw;
            s2   <= s1;
            rise <= (accept_c & s2) | rep_hit_c;
            fall <= accept_c & ~s2;
            if (tick_c) begin
                for (int i = 0; i < int'(NBit); i++) begin
                    if (s2[i] == level[i] || accept_c[i]) begin
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                    if (accept_c[i]) begin
                        level[i] <= s2[i];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_aux_input_conditioner.sv
// Directed + randomized bench for aux_input_conditioner against a run-length reference model.
module tb_aux_input_conditioner;
    localparam int unsigned NBit         = 4;
    localparam int unsigned TickCnt      = 4;
    localparam int unsigned StableCnt    = 3;
    localparam int unsigned RepeatDelay  = 5;
    localparam int unsigned RepeatPeriod = 2;
`ifdef AUX_INPUT_AUTOREPEAT_EN
    localparam bit AutoRep = 1'b1;
`else
    localparam bit AutoRep = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    aux_input_conditioner_if #(.NBit(NBit)) bus ();

    aux_input_conditioner #(
        .NBit(NBit), .TickCnt(TickCnt), .StableCnt(StableCnt),
        .RepeatDelay(RepeatDelay), .RepeatPeriod(RepeatPeriod)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    // Reference model: raw delayed two edges, tick on every TickCnt-th edge since reset,
    // level flips after StableCnt consecutive differing tick samples.
    logic [NBit-1:0] h1, h2, m_level, m_rise, m_fall;
    int k;
    int run  [NBit];
    int held [NBit];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_n, obs, expv);
        end
    endtask

    task automatic model_step(input logic rn, input logic [NBit-1:0] r);
        logic [NBit-1:0] s2m;
        bit tick;
        bit acc;
        m_rise = '0;
        m_fall = '0;
        if (!rn) begin
            h1 = '0; h2 = '0; k = 0; m_level = '0;
            for (int i = 0; i < int'(NBit); i++) begin
                run[i] = 0; held[i] = 0;
            end
            return;
        end
        s2m  = h2;
        tick = ((k % TickCnt) == TickCnt - 1);
        if (tick) begin
            for (int i = 0; i < int'(NBit); i++) begin
                acc = 1'b0;
                if (s2m[i] == m_level[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == int'(StableCnt)) begin
                        acc        = 1'b1;
                        run[i]     = 0;
                        m_level[i] = s2m[i];
                        held[i]    = 0;
                        if (s2m[i]) m_rise[i] = 1'b1;
                        else        m_fall[i] = 1'b1;
                    end
                end
                if (AutoRep && !acc && m_level[i]) begin
                    held[i]++;
                    if (held[i] >= int'(RepeatDelay) &&
                        ((held[i] - int'(RepeatDelay)) % int'(RepeatPeriod)) == 0)
                        m_rise[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < int'(NBit); i++) begin
            if (!m_level[i]) held[i] = 0;
        end
        h2 = h1;
        h1 = r;
        k++;
    endtask

    task automatic cyc(input logic [NBit-1:0] r, input logic rn = 1'b1);
        @(negedge clk);
        bus.raw = r;
        rst_n   = rn;
        @(posedge clk);
        model_step(rn, r);
        #1;
        cyc_n++;
        chk("level", 32'(bus.level), 32'(m_level));
        chk("rise",  32'(bus.rise),  32'(m_rise));
        chk("fall",  32'(bus.fall),  32'(m_fall));
    endtask

    int  n, nr, nf;
    bit  seen, bad;
    int  rq[$];
    logic [NBit-1:0] rv;
    bit  noisy;

    initial begin
        bus.raw = '0;

        // 1: reset then quiet input
        repeat (5) cyc(4'h0, 1'b0);
        chk("reset_outputs", 32'({bus.level, bus.rise, bus.fall}), 32'h0);
        bad = 1'b0;
        repeat (100) begin
            cyc(4'h0);
            if ({bus.level, bus.rise, bus.fall} != '0) bad = 1'b1;
        end
        chk("t1_quiet", 32'(bad), 32'h0);

        // 2: clean rise on bit 0
        n = 0; seen = 1'b0; nr = 0;
        while (n < 30 && !seen) begin
            n++;
            cyc(4'h1);
            if (bus.rise[0]) nr++;
            if (bus.level[0]) begin
                seen = 1'b1;
                chk("t2_rise_at_accept", 32'(bus.rise), 32'h1);
                chk("t2_level", 32'(bus.level), 32'h1);
            end
        end
        chk("t2_latency_ok", 32'(seen && n >= 11 && n <= 14), 32'h1);
        repeat (5) begin
            cyc(4'h1);
            if (bus.rise[0]) nr++;
        end
        chk("t2_single_rise", 32'(nr), 32'h1);

        // 3: short pulse and bounce on bit 1 are rejected
        bad = 1'b0;
        repeat (6) begin
            cyc(4'h3);
            if (bus.level[1] || bus.rise[1] || bus.fall[1]) bad = 1'b1;
        end
        repeat (30) begin
            cyc(4'h1);
            if (bus.level[1] || bus.rise[1] || bus.fall[1]) bad = 1'b1;
        end
        chk("t3_short_pulse", 32'(bad), 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(((i / 3) % 2 == 0) ? 4'h3 : 4'h1);
            if (bus.level[1] || bus.rise[1] || bus.fall[1]) bad = 1'b1;
        end
        repeat (20) begin
            cyc(4'h1);
            if (bus.level[1] || bus.rise[1] || bus.fall[1]) bad = 1'b1;
        end
        chk("t3_bounce", 32'(bad), 32'h0);

        // 4: fall on bit 0, then all bits rising together
        n = 0; seen = 1'b0; nf = 0;
        while (n < 30 && !seen) begin
            n++;
            cyc(4'h0);
            if (bus.fall[0]) begin
                seen = 1'b1;
                nf++;
                chk("t4_level_at_fall", 32'(bus.level), 32'h0);
            end
        end
        chk("t4_latency_ok", 32'(seen && n >= 11 && n <= 14), 32'h1);
        repeat (5) begin
            cyc(4'h0);
            if (bus.fall[0]) nf++;
        end
        chk("t4_single_fall", 32'(nf), 32'h1);
        n = 0; seen = 1'b0;
        while (n < 30 && !seen) begin
            n++;
            cyc(4'hF);
            if (bus.rise != '0) begin
                seen = 1'b1;
                chk("t4_rise_all", 32'(bus.rise), 32'hF);
                chk("t4_level_all", 32'(bus.level), 32'hF);
            end
        end
        chk("t4_rise_all_seen", 32'(seen), 32'h1);
        n = 0;
        while (n < 30 && bus.level != '0) begin
            n++;
            cyc(4'h0);
        end
        chk("t4_released", 32'(bus.level), 32'h0);
        repeat (4) cyc(4'h0);

        // 5: reset in the middle of a debounce
        n = 0;
        while (n < 30 && run[2] != 2) begin
            n++;
            cyc(4'h4);
        end
        chk("t5_two_ticks", 32'(run[2]), 32'h2);
        cyc(4'h4, 1'b0);
        chk("t5_reset_clears", 32'({bus.level, bus.rise, bus.fall}), 32'h0);
        n = 0; seen = 1'b0;
        while (n < 40 && !seen) begin
            n++;
            cyc(4'h4);
            if (bus.level[2]) seen = 1'b1;
        end
        chk("t5_fresh_accept", 32'(seen && n >= 10), 32'h1);
        n = 0;
        while (n < 30 && bus.level != '0) begin
            n++;
            cyc(4'h0);
        end
        chk("t5_released", 32'(bus.level), 32'h0);
        repeat (4) cyc(4'h0);

        // 6: long hold on bit 3 (auto-repeat when enabled), then release
        rq.delete();
        repeat (100) begin
            cyc(4'h8);
            if (bus.rise[3]) rq.push_back(cyc_n);
        end
`ifdef AUX_INPUT_AUTOREPEAT_EN
        chk("t6_repeats_ge3", 32'(rq.size() >= 3), 32'h1);
        if (rq.size() >= 3) begin
            chk("t6_gap_delay", 32'(rq[1] - rq[0]), 32'd20);
            for (int j = 2; j < rq.size(); j++) chk("t6_gap_period", 32'(rq[j] - rq[j-1]), 32'd8);
        end
`else
        chk("t6_single_rise", 32'(rq.size()), 32'h1);
`endif
        nr = 0; nf = 0;
        repeat (40) begin
            cyc(4'h0);
            if (bus.rise[3]) nr++;
            if (bus.fall[3]) nf++;
        end
        chk("t6_release_fall", 32'(nf), 32'h1);
        chk("t6_no_rise_after", 32'(nr), 32'h0);

        // Randomized phase: alternating calm and noisy windows, occasional reset.
        rv = '0;
        noisy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) noisy = ~noisy;
            for (int b = 0; b < int'(NBit); b++) begin
                if ($urandom_range(noisy ? 3 : 39, 0) == 0) rv[b] = ~rv[b];
            end
            cyc(rv, ($urandom_range(699, 0) == 0) ? 1'b0 : 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
